// File: rtl/tartaruga_pkg.sv
// Shared types and helpers for the tartaruga RV32 core pipeline stages.
package tartaruga_pkg;

  localparam int unsigned MAX_EXE_STAGES = 4;

  typedef logic [31:0] bus32_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_XOR, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic {RS1, PC} rs1_or_pc_t;
  typedef enum logic {RS2, IMM} rs2_or_imm_t;

  typedef enum logic [2:0] {
    BNONE, JUMP, BEQ, BNE, BLT, BGE, BLTU, BGEU
  } jump_kind_t;

  typedef struct packed {
    logic        valid;
    bus32_t      instr;
    bus32_t      pc;
    bus32_t      data_rs1;
    bus32_t      data_rs2;
    bus32_t      immediate;
    alu_op_t     alu_op;
    rs1_or_pc_t  rs1_or_pc;
    rs2_or_imm_t rs2_or_imm;
    jump_kind_t  jump_kind;
    logic        is_mul;
    logic [2:0]  exe_stages;
  } decode_to_exe_t;

  typedef struct packed {
    logic   valid;
    bus32_t instr;
    bus32_t result;
    bus32_t data_rs2;
    logic   branch_taken;
  } exe_to_mem_t;

  // Multiplies carry their low-word partial products until they enter the last slot.
  typedef struct packed {
    exe_to_mem_t exe;
    logic        is_mul;
    bus32_t      pp_ll;
    logic [15:0] pp_cross;
  } exe_slot_t;

  localparam exe_to_mem_t NOP_EXE = '{
    valid: 1'b0, instr: 32'h0000_0033, result: '0, data_rs2: '0, branch_taken: 1'b0
  };

  function automatic logic branch_cond(jump_kind_t kind, bus32_t a, bus32_t b);
    logic taken;
    case (kind)
      JUMP:    taken = 1'b1;
      BEQ:     taken = (a == b);
      BNE:     taken = (a != b);
      BLT:     taken = ($signed(a) < $signed(b));
      BGE:     taken = ($signed(a) >= $signed(b));
      BLTU:    taken = (a < b);
      BGEU:    taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU and branch comparator evaluated at slot insertion.
module exe_alu
  import tartaruga_pkg::*;
(
  input  decode_to_exe_t dec,
  output bus32_t         result,
  output logic           taken
);

  bus32_t     a;
  bus32_t     b;
  logic [4:0] shamt;

  always_comb begin
    a     = (dec.rs1_or_pc == PC) ? dec.pc : dec.data_rs1;
    b     = (dec.rs2_or_imm == IMM) ? dec.immediate : dec.data_rs2;
    shamt = b[4:0];
    case (dec.alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = bus32_t'($signed(a) >>> shamt);
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = a + b;
    endcase
  end

  assign taken = branch_cond(dec.jump_kind, dec.data_rs1, dec.data_rs2);

endmodule

// File: rtl/exe_pipe.sv
// Execute stage: variable-latency slot shift register keeping results in program order.
module exe_pipe
  import tartaruga_pkg::*;
#(
  parameter int unsigned MAX_STAGES = MAX_EXE_STAGES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  decode_to_exe_t decode_to_exe_i,
  output logic           stall_o,
  output exe_to_mem_t    exe_to_mem_o
);

  localparam exe_slot_t RESET_SLOT = '{exe: NOP_EXE, is_mul: 1'b0, pp_ll: '0, pp_cross: '0};

  exe_slot_t   slot_q [MAX_STAGES];
  exe_slot_t   slot_d [MAX_STAGES];
  exe_slot_t   ins;
  bus32_t      alu_result;
  logic        alu_taken;
  int unsigned lat;
  logic        busy;
  logic        accept;

  exe_alu u_alu (
    .dec    (decode_to_exe_i),
    .result (alu_result),
    .taken  (alu_taken)
  );

  always_comb begin
    lat = 32'(decode_to_exe_i.exe_stages);
    if (lat == 0) lat = 1;
    if (lat > MAX_STAGES) lat = MAX_STAGES;
  end

  // Any occupant ahead of the insertion slot would be overtaken or collided with.
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if ((i + lat < MAX_STAGES) && slot_q[i].exe.valid) busy = 1'b1;
    end
  end

  assign stall_o = decode_to_exe_i.valid && busy;
  assign accept  = decode_to_exe_i.valid && !stall_o && !flush_i;

  always_comb begin
    ins                  = '0;
    ins.exe.valid        = 1'b1;
    ins.exe.instr        = decode_to_exe_i.instr;
    ins.exe.result       = alu_result;
    ins.exe.data_rs2     = decode_to_exe_i.data_rs2;
    ins.exe.branch_taken = alu_taken;
    ins.is_mul           = decode_to_exe_i.is_mul;
    ins.pp_ll            = 32'(decode_to_exe_i.data_rs1[15:0]) * 32'(decode_to_exe_i.data_rs2[15:0]);
    ins.pp_cross         = decode_to_exe_i.data_rs1[15:0] * decode_to_exe_i.data_rs2[31:16]
                         + decode_to_exe_i.data_rs1[31:16] * decode_to_exe_i.data_rs2[15:0];
  end

  always_comb begin
    slot_d[0] = '0;
    for (int unsigned i = 1; i < MAX_STAGES; i++) begin
      slot_d[i] = slot_q[i-1];
    end
    if (accept) slot_d[MAX_STAGES-lat] = ins;
    // Every entry reaches the last slot exactly once, so the product is folded here.
    if (slot_d[MAX_STAGES-1].is_mul) begin
      slot_d[MAX_STAGES-1].exe.result = slot_d[MAX_STAGES-1].pp_ll
                                      + {slot_d[MAX_STAGES-1].pp_cross, 16'h0000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_STAGES; i++) slot_q[i] <= RESET_SLOT;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < MAX_STAGES; i++) slot_q[i].exe.valid <= 1'b0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign exe_to_mem_o = slot_q[MAX_STAGES-1].exe;

endmodule

// File: tb/tb_exe_pipe.sv
// Scoreboard bench for exe_pipe: ordering, latency, stall, flush and reset behaviour.
module tb_exe_pipe;
  import tartaruga_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  decode_to_exe_t din;
  logic           stall;
  exe_to_mem_t    dout;

  int          tests = 0;
  int          fails = 0;
  exe_to_mem_t exp_q[$];

  always #5 clk = ~clk;

  exe_pipe #(.MAX_STAGES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush),
    .decode_to_exe_i (din),
    .stall_o         (stall),
    .exe_to_mem_o    (dout)
  );

  // Every valid output is popped against the scoreboard in program order.
  always @(negedge clk) begin
    if (dout.valid === 1'b1) begin
      exe_to_mem_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output got instr=%h result=%h required no valid output",
                 dout.instr, dout.result);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL scoreboard got instr=%h res=%h rs2=%h bt=%b required instr=%h res=%h rs2=%h bt=%b",
                   dout.instr, dout.result, dout.data_rs2, dout.branch_taken,
                   e.instr, e.result, e.data_rs2, e.branch_taken);
        end
      end
    end
  end

  function automatic decode_to_exe_t mk(input alu_op_t op, input jump_kind_t jk, input logic mul,
                                        input logic [2:0] st, input bus32_t rs1, input bus32_t rs2,
                                        input bus32_t imm, input bus32_t pc, input logic use_pc,
                                        input logic use_imm, input bus32_t ibits);
    decode_to_exe_t d;
    d.valid      = 1'b1;
    d.instr      = ibits;
    d.pc         = pc;
    d.data_rs1   = rs1;
    d.data_rs2   = rs2;
    d.immediate  = imm;
    d.alu_op     = op;
    d.rs1_or_pc  = use_pc ? PC : RS1;
    d.rs2_or_imm = use_imm ? IMM : RS2;
    d.jump_kind  = jk;
    d.is_mul     = mul;
    d.exe_stages = st;
    return d;
  endfunction

  function automatic exe_to_mem_t expect_of(input decode_to_exe_t d, input bus32_t res, input logic bt);
    exe_to_mem_t e;
    e.valid        = 1'b1;
    e.instr        = d.instr;
    e.result       = res;
    e.data_rs2     = d.data_rs2;
    e.branch_taken = bt;
    return e;
  endfunction

  // Present d, wait (bounded) for it to be accepted, then drop valid after the edge.
  task automatic issue(input decode_to_exe_t d, input bus32_t res, input logic bt,
                       input logic push, output int stalls);
    int n;
    din    = d;
    stalls = 0;
    n      = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 8) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL issue_timeout got stall=%b required 0 within 8 cycles", stall);
    end
    if (push) exp_q.push_back(expect_of(d, res, bt));
    @(posedge clk);
    #1;
    din.valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    flush = 1'b0;
    din   = mk(ALU_ADD, BNONE, 1'b0, 3'd1, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0101);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (dout !== NOP_EXE) begin
      fails++;
      $display("FAIL reset_out got %h required %h", dout, NOP_EXE);
    end
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_stall got %b required 0", stall);
    end
    din.valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int s;
    issue(mk(ALU_ADD, BNONE, 1'b0, 3'd1, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b1, 32'h0000_0201),
          32'hFFFF_FFFE, 1'b0, 1'b1, s);
    tests++;
    if (s != 0) begin
      fails++;
      $display("FAIL add_stall got %0d stall cycles required 0", s);
    end
    @(negedge clk);
    tests++;
    if (dout.valid !== 1'b1 || dout.result !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL add_latency got v=%b res=%h required v=1 res=fffffffe", dout.valid, dout.result);
    end
    drain();
  endtask

  task automatic test_mul_then_add();
    decode_to_exe_t m;
    decode_to_exe_t a;
    m = mk(ALU_ADD, BNONE, 1'b1, 3'd4, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0301);
    a = mk(ALU_ADD, BNONE, 1'b0, 3'd1, 32'd10, 32'd20, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0302);
    din = m;
    @(negedge clk);
    exp_q.push_back(expect_of(m, 32'hFFFF_FFFD, 1'b0));
    @(posedge clk);
    #1;
    din = a;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests++;
      if (stall !== 1'b1) begin
        fails++;
        $display("FAIL mul_add_stall_c%0d got %b required 1", k, stall);
      end
    end
    @(negedge clk);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL mul_add_stall_c4 got %b required 0", stall);
    end
    tests++;
    if (dout.valid !== 1'b1 || dout.result !== 32'hFFFF_FFFD) begin
      fails++;
      $display("FAIL mul_result_edge3 got v=%b res=%h required v=1 res=fffffffd", dout.valid, dout.result);
    end
    exp_q.push_back(expect_of(a, 32'd30, 1'b0));
    @(posedge clk);
    #1;
    din.valid = 1'b0;
    @(negedge clk);
    tests++;
    if (dout.valid !== 1'b1 || dout.result !== 32'd30) begin
      fails++;
      $display("FAIL add_after_mul got v=%b res=%h required v=1 res=0000001e", dout.valid, dout.result);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bus32_t ra [4];
    bus32_t rb [4];
    int     s;
    int     total;
    ra = '{32'h1234_5678, 32'hFFFF_0001, 32'h8000_0000, 32'hDEAD_BEEF};
    rb = '{32'h9ABC_DEF0, 32'h0001_FFFF, 32'h0000_0003, 32'h0000_1000};
    total = 0;
    for (int i = 0; i < 4; i++) begin
      issue(mk(ALU_ADD, BNONE, 1'b1, 3'd4, ra[i], rb[i], 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0400 + i),
            ra[i] * rb[i], 1'b0, 1'b1, s);
      total += s;
    end
    tests++;
    if (total != 0) begin
      fails++;
      $display("FAIL b2b_mul_stall got %0d stall cycles required 0", total);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (dout.valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_mul_valid_%0d got %b required 1", i, dout.valid);
      end
    end
    drain();
  endtask

  task automatic test_branches();
    int s;
    issue(mk(ALU_ADD, BLT, 1'b0, 3'd1, 32'h8000_0000, 32'd1, 32'd8, 32'h100, 1'b1, 1'b1, 32'h0000_0501),
          32'h0000_0108, 1'b1, 1'b1, s);
    issue(mk(ALU_ADD, BLTU, 1'b0, 3'd1, 32'h8000_0000, 32'd1, 32'd8, 32'h100, 1'b1, 1'b1, 32'h0000_0502),
          32'h0000_0108, 1'b0, 1'b1, s);
    issue(mk(ALU_ADD, JUMP, 1'b0, 3'd1, 32'd7, 32'd9, 32'hFFFF_FFF0, 32'h200, 1'b1, 1'b1, 32'h0000_0503),
          32'h0000_01F0, 1'b1, 1'b1, s);
    issue(mk(ALU_ADD, BNONE, 1'b0, 3'd0, 32'd7, 32'd7, 32'd4, 32'h300, 1'b1, 1'b1, 32'h0000_0504),
          32'h0000_0304, 1'b0, 1'b1, s);
    issue(mk(ALU_ADD, BGE, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'd0, 32'd4, 32'h40, 1'b1, 1'b1, 32'h0000_0505),
          32'h0000_0044, 1'b0, 1'b1, s);
    drain();
  endtask

  task automatic test_shifts();
    int s;
    issue(mk(ALU_SRA, BNONE, 1'b0, 3'd1, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0601),
          32'hC000_0000, 1'b0, 1'b1, s);
    issue(mk(ALU_SLL, BNONE, 1'b0, 3'd1, 32'd1, 32'd0, 32'd31, 32'd0, 1'b0, 1'b1, 32'h0000_0602),
          32'h8000_0000, 1'b0, 1'b1, s);
    issue(mk(ALU_SRL, BNONE, 1'b0, 3'd1, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0603),
          32'h0800_0000, 1'b0, 1'b1, s);
    issue(mk(ALU_SLT, BNONE, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0604),
          32'd1, 1'b0, 1'b1, s);
    issue(mk(ALU_SUB, BNONE, 1'b0, 3'd7, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0605),
          32'hFFFF_FFFE, 1'b0, 1'b1, s);
    drain();
  endtask

  task automatic test_flush(input logic use_rst);
    int s;
    for (int i = 0; i < 2; i++) begin
      issue(mk(ALU_ADD, BNONE, 1'b1, 3'd4, 32'd6 + i, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0700 + i),
            32'd0, 1'b0, 1'b0, s);
    end
    din = mk(ALU_ADD, BNONE, 1'b0, 3'd4, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0710);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b0;
    din   = mk(ALU_ADD, BNONE, 1'b0, 3'd1, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0711);
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_stall_after rst=%b got %b required 0", use_rst, stall);
    end
    if (use_rst) begin
      tests++;
      if (dout !== NOP_EXE) begin
        fails++;
        $display("FAIL rst_nop got %h required %h", dout, NOP_EXE);
      end
    end
    din.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (dout.valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_quiet_%0d rst=%b got valid=%b required 0", k, use_rst, dout.valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    din   = '0;
    rst   = 1'b1;
    flush = 1'b0;
    test_reset();
    test_add();
    test_mul_then_add();
    test_back_to_back();
    test_branches();
    test_shifts();
    test_flush(1'b0);
    test_flush(1'b1);
    test_add();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_queue got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
